// File: rtl/load_store_unit.sv
// Load/store unit: turns one execute-stage memory request into a word-aligned
// bus transaction with byte lanes, alignment checking and a bounded wait for mem_ready.
`timescale 1ns/1ps
module load_store_unit #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [1:0]  DataType,
    input  logic [31:0] Addr,
    input  logic [31:0] WriteData,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    output logic [31:0] ReadData,
    output logic        Stall,
    output logic        Misaligned,
    output logic        BusErr,
    output logic [1:0]  state_o
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   addr_q, addr_d;
    logic [1:0]    dtype_q, dtype_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          we_q, we_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          misal_q, misal_d;
    logic          buserr_q, buserr_d;

    logic          req_any;
    logic          addr_bad;
    logic [3:0]    lane_be;
    logic [31:0]   lane_wdata;
    logic [31:0]   load_data;
    logic [31:0]   byte_sh;
    logic [31:0]   half_sh;

    assign req_any = MemRead | MemWrite;

    // Encoding 11 is treated as a word access everywhere.
    always_comb begin
        addr_bad = 1'b0;
        case (DataType)
            2'b01:   addr_bad = 1'b0;
            2'b10:   addr_bad = Addr[0];
            default: addr_bad = (Addr[1:0] != 2'b00);
        endcase
    end

    assign byte_sh = mem_rdata >> {addr_q[1:0], 3'b000};
    assign half_sh = mem_rdata >> {addr_q[1], 4'b0000};

    always_comb begin
        lane_be    = 4'b1111;
        lane_wdata = wdata_q;
        load_data  = mem_rdata;
        case (dtype_q)
            2'b01: begin
                lane_be    = 4'b0001 << addr_q[1:0];
                lane_wdata = {4{wdata_q[7:0]}};
                load_data  = {24'h0, byte_sh[7:0]};
            end
            2'b10: begin
                lane_be    = addr_q[1] ? 4'b1100 : 4'b0011;
                lane_wdata = {2{wdata_q[15:0]}};
                load_data  = {16'h0, half_sh[15:0]};
            end
            default: begin
                lane_be    = 4'b1111;
                lane_wdata = wdata_q;
                load_data  = mem_rdata;
            end
        endcase
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        dtype_d  = dtype_q;
        wdata_d  = wdata_q;
        we_d     = we_q;
        cnt_d    = cnt_q;
        rdata_d  = rdata_q;
        misal_d  = 1'b0;
        buserr_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_any) begin
                    if (addr_bad) begin
                        state_d = DONE;
                        misal_d = 1'b1;
                    end else begin
                        state_d = REQ;
                        addr_d  = Addr;
                        dtype_d = DataType;
                        wdata_d = WriteData;
                        we_d    = MemWrite;
                        cnt_d   = '0;
                    end
                end
            end
            REQ: begin
                if (mem_ready) begin
                    state_d = DONE;
                    if (!we_q) rdata_d = load_data;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    state_d  = DONE;
                    buserr_d = 1'b1;
                    rdata_d  = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            dtype_q  <= '0;
            wdata_q  <= '0;
            we_q     <= 1'b0;
            cnt_q    <= '0;
            rdata_q  <= '0;
            misal_q  <= 1'b0;
            buserr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            dtype_q  <= dtype_d;
            wdata_q  <= wdata_d;
            we_q     <= we_d;
            cnt_q    <= cnt_d;
            rdata_q  <= rdata_d;
            misal_q  <= misal_d;
            buserr_q <= buserr_d;
        end
    end

    // Fault flags are only ever set on the edge into DONE, so they last one cycle.
    assign mem_req    = (state_q == REQ);
    assign mem_we     = (state_q == REQ) & we_q;
    assign mem_be     = (state_q == REQ) ? lane_be : 4'b0000;
    assign mem_addr   = {addr_q[31:2], 2'b00};
    assign mem_wdata  = lane_wdata;
    assign ReadData   = rdata_q;
    assign Stall      = ((state_q == IDLE) & req_any) | (state_q == REQ);
    assign Misaligned = misal_q;
    assign BusErr     = buserr_q;
    assign state_o    = state_q;

endmodule
